mpsoc_msi_wb_downsizer: RTL and testbench
=========================================

Name: mpsoc_msi_wb_downsizer

Overview:
Wishbone data-width converter from a wide master to a narrow slave. It is the reverse direction of mpsoc_msi_wb_upsizer. Each wide access of DW_IN bits is split into up to SCALE sequential narrow accesses of DW_OUT bits. Read data is reassembled into one wide word. The block sits between a 64-bit initiator and 32-bit peripherals or memories in the MPSoC interconnect.

Parameters:
AW, 32, address width (byte address).
DW_IN, 64, wide-side data width; multiple of 8.
SCALE, 2, ratio DW_IN/DW_OUT; power of two, >=2.
DW_OUT, DW_IN/SCALE, localparam; narrow-side data width; must be >=8.

Ports:
wb_clk_i  in  1  clock, rising edge.
wb_rst_ni  in  1  asynchronous active-low reset.
wbs_adr_i  in  AW  wide request byte address.
wbs_dat_i  in  DW_IN  write data.
wbs_sel_i  in  DW_IN/8  byte enables.
wbs_we_i  in  1  write enable.
wbs_cyc_i  in  1  cycle.
wbs_stb_i  in  1  strobe.
wbs_cti_i  in  3  accepted, not forwarded.
wbs_bte_i  in  2  accepted, not forwarded.
wbs_dat_o  out  DW_IN  assembled read data.
wbs_ack_o  out  1  wide ack.
wbs_err_o  out  1  wide error.
wbs_rty_o  out  1  wide retry.
wbm_adr_o  out  AW  narrow beat address.
wbm_dat_o  out  DW_OUT  narrow write data.
wbm_sel_o  out  DW_OUT/8  narrow byte enables.
wbm_we_o  out  1  write enable.
wbm_cyc_o  out  1  cycle.
wbm_stb_o  out  1  strobe.
wbm_cti_o  out  3  cycle type.
wbm_bte_o  out  2  burst type; constant 2'b00.
wbm_dat_i  in  DW_OUT  narrow read data.
wbm_ack_i  in  1  narrow ack.
wbm_err_i  in  1  narrow error.
wbm_rty_i  in  1  narrow retry.

Behaviour:
- Reset: async on wb_rst_ni=0. All outputs go to 0 and the FSM goes to IDLE.
- Lane order: lane k covers wide bits [k*DW_OUT +: DW_OUT] (little-endian). Lane k address = {adr[AW-1:log2(DW_IN/8)], k, log2(DW_OUT/8) zero bits}.
- FSM states are IDLE, XFER and RESP.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i at a clock edge, latch adr, dat, sel and we.
  - Compute the active-lane mask: lane k is active when its sel slice is nonzero. If sel==0, lane 0 alone is active with sel 0.
  - Set the current lane to the lowest active lane and go to XFER.
- XFER:
  - wbm_cyc_o=wbm_stb_o=1. adr, dat and sel are driven from the current lane.
  - wbm_cti_o = 3'b000 if exactly one lane is active. Otherwise 3'b010 for every beat except the last active lane, which gets 3'b111.
- Narrow ack in XFER:
  - Store wbm_dat_i into the read buffer slice of the current lane. Inactive lanes read as 0.
  - If this is the last active lane, go to RESP. Otherwise advance to the next active lane with stb held high (no idle cycle).
- Narrow err or rty in XFER: abort the remaining lanes, record which one occurred and go to RESP.
- RESP:
  - wbm_cyc_o=wbm_stb_o=0.
  - Exactly one of wbs_ack_o, wbs_err_o or wbs_rty_o is high for exactly one cycle; wbs_dat_o is valid.
  - Go to IDLE.
- Latency with a zero-wait slave: request seen at edge 0, beats at cycles 1..N (N = active lanes), wide ack in cycle N+1. The next request is accepted no earlier than the following edge.
- Wide burst cti/bte are not honoured. Each wide beat is an independent access, with one ack per wide beat.
- wbs_cyc_i dropped during XFER:
  - Next edge goes to IDLE with wbm_cyc_o/wbm_stb_o=0.
  - No wide response is issued. A narrow ack arriving in that same cycle is discarded.
- Simultaneous ack and err on the narrow side: err wins. Simultaneous err and rty: err wins.
- wbs_dat_o holds its last value outside RESP; bench checks it only in RESP.

Decomposition:
- Package mpsoc_msi_wb_pkg holds:
  - CTI constants CLASSIC=3'b000, INC=3'b010, EOB=3'b111; BTE_LINEAR=2'b00.
  - The state enum type.
- One sub-module, mpsoc_msi_wb_downsizer_lane_sel. It is combinational: given the active mask and current lane, it returns next lane, is_last and the first lane.

Test Plan:
- Write adr 0x100, sel 0xFF, dat 0x1122334455667788 -> two beats: 0x100/0x55667788/sel F/cti 010 then 0x104/0x11223344/sel F/cti 111. One wbs_ack_o pulse in cycle 3.
- Read adr 0x200, sel 0xFF, memory 0x200=0xAAAA0001 and 0x204=0xBBBB0002 -> wbs_dat_o=0xBBBB0002AAAA0001 with ack.
- Write sel 0xF0 adr 0x108 -> single beat at 0x10C, cti 000, sel F. Sel 0x0F -> single beat at 0x108.
- Read sel 0xFF with the slave asserting err on the 0x104 beat -> one wbs_err_o pulse, no wbs_ack_o, wbm_cyc_o low in the next cycle.
- Drop wbs_cyc_i after the first narrow beat -> wbm_cyc_o low next edge, no wide response. The next request completes normally.
- Assert wb_rst_ni low mid-XFER -> all outputs 0 immediately. After release, a read of 0x200 returns the correct data.

Source files
------------

// File: rtl/mpsoc_msi_wb_pkg.sv
// Shared Wishbone constants and the downsizer FSM state type.
package mpsoc_msi_wb_pkg;

    localparam logic [2:0] CLASSIC    = 3'b000;
    localparam logic [2:0] INC        = 3'b010;
    localparam logic [2:0] EOB        = 3'b111;
    localparam logic [1:0] BTE_LINEAR = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_RESP
    } state_e;

endpackage

// File: rtl/mpsoc_msi_wb_downsizer_lane_sel.sv
// Active-lane walker: first active lane, next active lane above the current one,
// and whether the current lane is the highest active lane.
module mpsoc_msi_wb_downsizer_lane_sel #(
    parameter int unsigned SCALE = 2
) (
    input  logic [SCALE-1:0]         mask,
    input  logic [$clog2(SCALE)-1:0] lane,
    output logic [$clog2(SCALE)-1:0] first_lane,
    output logic [$clog2(SCALE)-1:0] next_lane,
    output logic                     is_last
);

    localparam int unsigned LW = $clog2(SCALE);

    // Descending scan so the lowest qualifying lane is the one left standing.
    always_comb begin
        first_lane = '0;
        next_lane  = lane;
        is_last    = 1'b1;
        for (int k = SCALE - 1; k >= 0; k--) begin
            if (mask[k]) begin
                first_lane = LW'(k);
                if (LW'(k) > lane) begin
                    next_lane = LW'(k);
                    is_last   = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mpsoc_msi_wb_downsizer.sv
// Wishbone width converter: splits each wide access into narrow beats over the
// active lanes and reassembles read data into one wide response.
module mpsoc_msi_wb_downsizer
    import mpsoc_msi_wb_pkg::*;
#(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW_IN = 64,
    parameter int unsigned SCALE = 2
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic [AW-1:0]             wbs_adr_i,
    input  logic [DW_IN-1:0]          wbs_dat_i,
    input  logic [DW_IN/8-1:0]        wbs_sel_i,
    input  logic                      wbs_we_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic [2:0]                wbs_cti_i,
    input  logic [1:0]                wbs_bte_i,
    output logic [DW_IN-1:0]          wbs_dat_o,
    output logic                      wbs_ack_o,
    output logic                      wbs_err_o,
    output logic                      wbs_rty_o,
    output logic [AW-1:0]             wbm_adr_o,
    output logic [DW_IN/SCALE-1:0]    wbm_dat_o,
    output logic [DW_IN/SCALE/8-1:0]  wbm_sel_o,
    output logic                      wbm_we_o,
    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic [2:0]                wbm_cti_o,
    output logic [1:0]                wbm_bte_o,
    input  logic [DW_IN/SCALE-1:0]    wbm_dat_i,
    input  logic                      wbm_ack_i,
    input  logic                      wbm_err_i,
    input  logic                      wbm_rty_i
);

    localparam int unsigned DW_OUT  = DW_IN / SCALE;
    localparam int unsigned SW_IN   = DW_IN / 8;
    localparam int unsigned SW_OUT  = DW_OUT / 8;
    localparam int unsigned LW      = $clog2(SCALE);
    localparam int unsigned OFF_OUT = $clog2(SW_OUT);

    state_e              state_q, state_d;
    logic [AW-1:0]       adr_q, adr_d;
    logic [DW_IN-1:0]    dat_q, dat_d;
    logic [SW_IN-1:0]    sel_q, sel_d;
    logic [SCALE-1:0]    mask_q, mask_d, new_mask, mask_c;
    logic [LW-1:0]       lane_q, lane_d;
    logic [DW_IN-1:0]    rdata_q, rdata_d;

    logic [AW-1:0]       wbm_adr_d;
    logic [DW_OUT-1:0]   wbm_dat_d;
    logic [SW_OUT-1:0]   wbm_sel_d;
    logic                wbm_we_d, wbm_cyc_d, wbm_stb_d;
    logic [2:0]          wbm_cti_d;
    logic                wbs_ack_d, wbs_err_d, wbs_rty_d;
    logic [DW_IN-1:0]    wbs_dat_d;

    logic [LW-1:0]       first_a, next_a, lane_b;
    logic                last_a, last_b;
    logic [LW-1:0]       unused_first_b, unused_next_b;
    logic                unused_in;

    assign unused_in = ^{wbs_cti_i, wbs_bte_i};
    assign wbm_bte_o = BTE_LINEAR;

    function automatic logic [AW-1:0] lane_adr(input logic [AW-1:0] a, input logic [LW-1:0] ln);
        return (a & ~AW'(SW_IN - 1)) | (AW'(ln) << OFF_OUT);
    endfunction

    // A lane is active when any of its byte enables is set; an empty sel still issues lane 0.
    always_comb begin
        new_mask = '0;
        for (int k = 0; k < SCALE; k++) begin
            new_mask[k] = |wbs_sel_i[k*SW_OUT +: SW_OUT];
        end
        if (new_mask == '0) begin
            new_mask[0] = 1'b1;
        end
    end

    assign mask_c = (state_q == ST_IDLE) ? new_mask : mask_q;
    // Second walker looks one step ahead to pick the cti of the beat about to be issued.
    assign lane_b = (state_q == ST_IDLE) ? first_a : next_a;

    mpsoc_msi_wb_downsizer_lane_sel #(.SCALE(SCALE)) u_sel_cur (
        .mask       (mask_c),
        .lane       (lane_q),
        .first_lane (first_a),
        .next_lane  (next_a),
        .is_last    (last_a)
    );

    mpsoc_msi_wb_downsizer_lane_sel #(.SCALE(SCALE)) u_sel_nxt (
        .mask       (mask_c),
        .lane       (lane_b),
        .first_lane (unused_first_b),
        .next_lane  (unused_next_b),
        .is_last    (last_b)
    );

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        mask_d    = mask_q;
        lane_d    = lane_q;
        rdata_d   = rdata_q;
        wbm_adr_d = wbm_adr_o;
        wbm_dat_d = wbm_dat_o;
        wbm_sel_d = wbm_sel_o;
        wbm_we_d  = wbm_we_o;
        wbm_cti_d = wbm_cti_o;
        wbm_cyc_d = 1'b0;
        wbm_stb_d = 1'b0;
        wbs_ack_d = 1'b0;
        wbs_err_d = 1'b0;
        wbs_rty_d = 1'b0;
        wbs_dat_d = wbs_dat_o;

        unique case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    state_d   = ST_XFER;
                    adr_d     = wbs_adr_i;
                    dat_d     = wbs_dat_i;
                    sel_d     = wbs_sel_i;
                    mask_d    = new_mask;
                    lane_d    = first_a;
                    rdata_d   = '0;
                    wbm_cyc_d = 1'b1;
                    wbm_stb_d = 1'b1;
                    wbm_adr_d = lane_adr(wbs_adr_i, first_a);
                    wbm_dat_d = wbs_dat_i[int'(first_a)*DW_OUT +: DW_OUT];
                    wbm_sel_d = wbs_sel_i[int'(first_a)*SW_OUT +: SW_OUT];
                    wbm_we_d  = wbs_we_i;
                    wbm_cti_d = last_b ? CLASSIC : INC;
                end
            end
            ST_XFER: begin
                wbm_cyc_d = 1'b1;
                wbm_stb_d = 1'b1;
                if (!wbs_cyc_i) begin
                    // Master abandoned the cycle: quietly drop it, no wide response.
                    state_d   = ST_IDLE;
                    wbm_cyc_d = 1'b0;
                    wbm_stb_d = 1'b0;
                end else if (wbm_err_i || wbm_rty_i) begin
                    state_d   = ST_RESP;
                    wbm_cyc_d = 1'b0;
                    wbm_stb_d = 1'b0;
                    wbs_err_d = wbm_err_i;
                    wbs_rty_d = !wbm_err_i;
                    wbs_dat_d = rdata_q;
                end else if (wbm_ack_i) begin
                    rdata_d[int'(lane_q)*DW_OUT +: DW_OUT] = wbm_dat_i;
                    if (last_a) begin
                        state_d   = ST_RESP;
                        wbm_cyc_d = 1'b0;
                        wbm_stb_d = 1'b0;
                        wbs_ack_d = 1'b1;
                        wbs_dat_d = rdata_d;
                    end else begin
                        lane_d    = next_a;
                        wbm_adr_d = lane_adr(adr_q, next_a);
                        wbm_dat_d = dat_q[int'(next_a)*DW_OUT +: DW_OUT];
                        wbm_sel_d = sel_q[int'(next_a)*SW_OUT +: SW_OUT];
                        wbm_cti_d = last_b ? EOB : INC;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            mask_q    <= '0;
            lane_q    <= '0;
            rdata_q   <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_cti_o <= '0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_rty_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            mask_q    <= mask_d;
            lane_q    <= lane_d;
            rdata_q   <= rdata_d;
            wbm_adr_o <= wbm_adr_d;
            wbm_dat_o <= wbm_dat_d;
            wbm_sel_o <= wbm_sel_d;
            wbm_we_o  <= wbm_we_d;
            wbm_cyc_o <= wbm_cyc_d;
            wbm_stb_o <= wbm_stb_d;
            wbm_cti_o <= wbm_cti_d;
            wbs_ack_o <= wbs_ack_d;
            wbs_err_o <= wbs_err_d;
            wbs_rty_o <= wbs_rty_d;
            wbs_dat_o <= wbs_dat_d;
        end
    end

endmodule

// File: tb/tb_mpsoc_msi_wb_downsizer.sv
// Directed bench for the 64->32 Wishbone downsizer with a zero-wait narrow slave
// and queued expectations for narrow beats and wide responses.
module tb_mpsoc_msi_wb_downsizer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] wbs_adr;
    logic [63:0] wbs_dat;
    logic [7:0]  wbs_sel;
    logic        wbs_we, wbs_cyc, wbs_stb;
    logic [2:0]  wbs_cti;
    logic [1:0]  wbs_bte;
    logic [63:0] wbs_rdat;
    logic        wbs_ack, wbs_err, wbs_rty;
    logic [31:0] wbm_adr, wbm_wdat, wbm_rdat;
    logic [3:0]  wbm_sel;
    logic        wbm_we, wbm_cyc, wbm_stb;
    logic [2:0]  wbm_cti;
    logic [1:0]  wbm_bte;
    logic        wbm_ack, wbm_err, wbm_rty;
    logic        err_en;
    logic [31:0] err_adr;

    mpsoc_msi_wb_downsizer dut (
        .wb_clk_i (clk),      .wb_rst_ni (rst_n),
        .wbs_adr_i(wbs_adr),  .wbs_dat_i(wbs_dat),  .wbs_sel_i(wbs_sel),
        .wbs_we_i (wbs_we),   .wbs_cyc_i(wbs_cyc),  .wbs_stb_i(wbs_stb),
        .wbs_cti_i(wbs_cti),  .wbs_bte_i(wbs_bte),
        .wbs_dat_o(wbs_rdat), .wbs_ack_o(wbs_ack),  .wbs_err_o(wbs_err),
        .wbs_rty_o(wbs_rty),
        .wbm_adr_o(wbm_adr),  .wbm_dat_o(wbm_wdat), .wbm_sel_o(wbm_sel),
        .wbm_we_o (wbm_we),   .wbm_cyc_o(wbm_cyc),  .wbm_stb_o(wbm_stb),
        .wbm_cti_o(wbm_cti),  .wbm_bte_o(wbm_bte),
        .wbm_dat_i(wbm_rdat), .wbm_ack_i(wbm_ack),  .wbm_err_i(wbm_err),
        .wbm_rty_i(wbm_rty)
    );

    // Zero-wait narrow slave; errors on one programmable address.
    assign wbm_err  = wbm_cyc & wbm_stb & err_en & (wbm_adr == err_adr);
    assign wbm_ack  = wbm_cyc & wbm_stb & ~wbm_err;
    assign wbm_rty  = 1'b0;
    assign wbm_rdat = (wbm_adr == 32'h200) ? 32'hAAAA0001 :
                      (wbm_adr == 32'h204) ? 32'hBBBB0002 : {16'hC0DE, wbm_adr[15:0]};

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [2:0]  cti;
    } beat_t;

    typedef struct packed {
        logic [2:0]  kind;
        logic [63:0] dat;
        logic        chk_dat;
        logic [7:0]  cyc;
    } resp_t;

    beat_t exp_beats[$];
    resp_t exp_resp[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] all_out();
        return 192'({wbs_rdat, wbs_ack, wbs_err, wbs_rty, wbm_adr, wbm_wdat, wbm_sel,
                     wbm_we, wbm_cyc, wbm_stb, wbm_cti, wbm_bte});
    endfunction

    task automatic push_beat(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic we, input logic [2:0] cti);
        beat_t b;
        b.adr = adr; b.dat = dat; b.sel = sel; b.we = we; b.cti = cti;
        exp_beats.push_back(b);
    endtask

    task automatic push_resp(input logic [2:0] kind, input logic [63:0] dat,
                             input logic chk_dat, input logic [7:0] cyc);
        resp_t r;
        r.kind = kind; r.dat = dat; r.chk_dat = chk_dat; r.cyc = cyc;
        exp_resp.push_back(r);
    endtask

    task automatic check_beat(input string tag);
        beat_t o, e;
        o.adr = wbm_adr; o.dat = wbm_wdat; o.sel = wbm_sel; o.we = wbm_we; o.cti = wbm_cti;
        chk({tag, "_beat_avail"}, 192'(exp_beats.size() > 0), 192'(1));
        if (exp_beats.size() > 0) begin
            e = exp_beats.pop_front();
            chk({tag, "_beat"}, 192'({o, wbm_bte}), 192'({e, 2'b00}));
        end
    endtask

    // Issue one wide access at a negedge and follow it until response or abandon.
    task automatic access(input string tag, input logic we, input logic [31:0] adr,
                          input logic [7:0] sel, input logic [63:0] dat, input int drop_at);
        int    nb      = 0;
        bit    done    = 1'b0;
        bit    dropped = 1'b0;
        bit    seen;
        resp_t e;
        wbs_we = we; wbs_adr = adr; wbs_sel = sel; wbs_dat = dat;
        wbs_cyc = 1'b1; wbs_stb = 1'b1;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk);
            if (dropped) begin
                chk({tag, "_cyc_low"}, 192'({wbm_cyc, wbm_stb}), 192'(0));
                seen = wbs_ack | wbs_err | wbs_rty;
                repeat (4) begin
                    @(negedge clk);
                    seen = seen | wbs_ack | wbs_err | wbs_rty;
                end
                chk({tag, "_no_resp"}, 192'(seen), 192'(0));
                done = 1'b1;
            end else begin
                if (wbm_cyc && wbm_stb) begin
                    check_beat(tag);
                    if (nb == drop_at) begin
                        wbs_cyc = 1'b0; wbs_stb = 1'b0; dropped = 1'b1;
                    end
                    nb++;
                end
                if (wbs_ack | wbs_err | wbs_rty) begin
                    chk({tag, "_resp_avail"}, 192'(exp_resp.size() > 0), 192'(1));
                    if (exp_resp.size() > 0) begin
                        e = exp_resp.pop_front();
                        chk({tag, "_kind"}, 192'({wbm_cyc, wbs_rty, wbs_err, wbs_ack}), 192'({1'b0, e.kind}));
                        chk({tag, "_cycle"}, 192'(i), 192'(e.cyc));
                        if (e.chk_dat) chk({tag, "_rdata"}, 192'(wbs_rdat), 192'(e.dat));
                    end
                    wbs_cyc = 1'b0; wbs_stb = 1'b0;
                    @(negedge clk);
                    chk({tag, "_pulse"}, 192'({wbm_cyc, wbs_ack, wbs_err, wbs_rty}), 192'(0));
                    done = 1'b1;
                end
            end
        end
        chk({tag, "_done"}, 192'(done), 192'(1));
    endtask

    initial begin
        wbs_adr = '0; wbs_dat = '0; wbs_sel = '0; wbs_we = 1'b0;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_cti = 3'b010; wbs_bte = 2'b01;
        err_en = 1'b0; err_adr = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out(), 192'(0));
        rst_n = 1'b1;
        @(negedge clk);

        push_beat(32'h100, 32'h55667788, 4'hF, 1'b1, 3'b010);
        push_beat(32'h104, 32'h11223344, 4'hF, 1'b1, 3'b111);
        push_resp(3'b001, 64'h0, 1'b0, 8'd3);
        access("wr_full", 1'b1, 32'h100, 8'hFF, 64'h1122334455667788, -1);

        push_beat(32'h200, 32'h0, 4'hF, 1'b0, 3'b010);
        push_beat(32'h204, 32'h0, 4'hF, 1'b0, 3'b111);
        push_resp(3'b001, 64'hBBBB0002AAAA0001, 1'b1, 8'd3);
        access("rd_full", 1'b0, 32'h200, 8'hFF, 64'h0, -1);

        push_beat(32'h10C, 32'hDEADBEEF, 4'hF, 1'b1, 3'b000);
        push_resp(3'b001, 64'h0, 1'b0, 8'd2);
        access("wr_hi", 1'b1, 32'h108, 8'hF0, 64'hDEADBEEFCAFEF00D, -1);

        push_beat(32'h108, 32'hCAFEF00D, 4'hF, 1'b1, 3'b000);
        push_resp(3'b001, 64'h0, 1'b0, 8'd2);
        access("wr_lo", 1'b1, 32'h108, 8'h0F, 64'hDEADBEEFCAFEF00D, -1);

        push_beat(32'h204, 32'h0, 4'h3, 1'b0, 3'b000);
        push_resp(3'b001, 64'hBBBB000200000000, 1'b1, 8'd2);
        access("rd_partial", 1'b0, 32'h200, 8'h30, 64'h0, -1);

        push_beat(32'h110, 32'h89ABCDEF, 4'h0, 1'b1, 3'b000);
        push_resp(3'b001, 64'h0, 1'b0, 8'd2);
        access("wr_nosel", 1'b1, 32'h110, 8'h00, 64'h0123456789ABCDEF, -1);

        err_en = 1'b1; err_adr = 32'h104;
        push_beat(32'h100, 32'h0, 4'hF, 1'b0, 3'b010);
        push_beat(32'h104, 32'h0, 4'hF, 1'b0, 3'b111);
        push_resp(3'b010, 64'h0, 1'b0, 8'd3);
        access("rd_err", 1'b0, 32'h100, 8'hFF, 64'h0, -1);
        err_en = 1'b0;

        push_beat(32'h300, 32'h0, 4'hF, 1'b0, 3'b010);
        push_beat(32'h304, 32'h0, 4'hF, 1'b0, 3'b111);
        access("rd_drop", 1'b0, 32'h300, 8'hFF, 64'h0, 1);

        push_beat(32'h200, 32'h0, 4'hF, 1'b0, 3'b010);
        push_beat(32'h204, 32'h0, 4'hF, 1'b0, 3'b111);
        push_resp(3'b001, 64'hBBBB0002AAAA0001, 1'b1, 8'd3);
        access("rd_after_drop", 1'b0, 32'h200, 8'hFF, 64'h0, -1);

        // Reset asserted while the first narrow beat is on the bus.
        push_beat(32'h200, 32'h0, 4'hF, 1'b0, 3'b010);
        wbs_we = 1'b0; wbs_adr = 32'h200; wbs_sel = 8'hFF; wbs_dat = '0;
        wbs_cyc = 1'b1; wbs_stb = 1'b1;
        @(negedge clk);
        check_beat("rst_mid");
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", all_out(), 192'(0));
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        push_beat(32'h200, 32'h0, 4'hF, 1'b0, 3'b010);
        push_beat(32'h204, 32'h0, 4'hF, 1'b0, 3'b111);
        push_resp(3'b001, 64'hBBBB0002AAAA0001, 1'b1, 8'd3);
        access("rd_after_rst", 1'b0, 32'h200, 8'hFF, 64'h0, -1);

        chk("beats_left", 192'(exp_beats.size()), 192'(0));
        chk("resp_left", 192'(exp_resp.size()), 192'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
